led_bank_arbiter: RTL and testbench

Shares the board's five user LEDs between up to NREQ requesting blocks, such as the heartbeat counter, debug status and error flags, so that exactly one requester drives the bank at a time. Arbitration is round-robin with a minimum-tenure timer, and the owner's pattern passes through a per-owner PWM brightness stage. The block sits in the FPGA top level between the requesters and the led1..led5 pins. It runs on the global-buffered clock.

---
 rtl/led_bank_arbiter.sv | 68 ++++++
 tb/tb_led_bank_arbiter.sv | 184 ++++++++++++++++++
 2 files changed

// File: rtl/led_bank_arbiter.sv
// led_bank_arbiter: round-robin ownership of the five user LEDs with a minimum tenure and per-owner PWM dimming.
module led_bank_arbiter #(
    parameter int NREQ        = 3,
    parameter int HOLD_CYCLES = 12_000_000,
    parameter int HOLD_W      = 24,
    parameter int PWM_W       = 4
) (
    input  logic                    clk,
    input  logic                    resetn,
    input  logic [NREQ-1:0]         req,
    input  logic [5*NREQ-1:0]       pat,
    input  logic [PWM_W*NREQ-1:0]   duty,
    output logic [NREQ-1:0]         gnt,
    output logic                    busy,
    output logic                    led1,
    output logic                    led2,
    output logic                    led3,
    output logic                    led4,
    output logic                    led5
);
    localparam int IW = $clog2(NREQ);
    typedef enum logic [1:0] {IDLE, OWN, GAP} state_t;
    state_t state, state_nx;
    logic [IW-1:0] last, win;
    logic [HOLD_W-1:0] tenure;
    logic [PWM_W-1:0] pcnt;
    logic [4:0] led;
    logic [4:0] pat_a [NREQ];
    logic [PWM_W-1:0] duty_a [NREQ];
    logic sat, leave, grab, pwm_on;
    for (genvar i = 0; i < NREQ; i++) begin : g_slice
        assign pat_a[i]  = pat[5*i +: 5];
        assign duty_a[i] = duty[PWM_W*i +: PWM_W];
    end
    // requesters above last outrank those at or below it; lowest index wins within each group
    always_comb begin
        win = last;
        for (int j = NREQ - 1; j >= 0; j--)
            if (req[j] && j <= int'(last)) win = IW'(j);
        for (int j = NREQ - 1; j >= 0; j--)
            if (req[j] && j > int'(last)) win = IW'(j);
        sat      = tenure == HOLD_W'(HOLD_CYCLES);
        leave    = state == OWN && (!req[last] || (sat && |(req & ~gnt)));
        grab     = state != OWN && |req;
        pwm_on   = pcnt < duty_a[last] || &duty_a[last];
        state_nx = state == OWN ? (leave ? GAP : OWN) : (grab ? OWN : IDLE);
    end
    always_ff @(posedge clk) begin
        if (!resetn) begin
            state  <= IDLE;
            gnt    <= '0;
            busy   <= 1'b0;
            led    <= '0;
            tenure <= '0;
            pcnt   <= '0;
            last   <= IW'(NREQ - 1);
        end else begin
            state  <= state_nx;
            pcnt   <= pcnt + 1'b1;
            gnt    <= grab ? NREQ'(1) << win : (leave ? '0 : gnt);
            busy   <= grab || (state == OWN && !leave);
            last   <= grab ? win : last;
            tenure <= grab ? '0 : (state == OWN && !sat) ? tenure + 1'b1 : tenure;
            led    <= (state == OWN && !leave) ? pat_a[last] & {5{pwm_on}} : '0;
        end
    end
    assign {led1, led2, led3, led4, led5} = led;
endmodule

// File: tb/tb_led_bank_arbiter.sv
// tb_led_bank_arbiter: directed stimulus checked every cycle against a behavioural ownership model.
module tb_led_bank_arbiter;
    localparam int NREQ = 3;
    localparam int HOLD = 8;
    logic clk = 1'b0;
    logic resetn;
    logic [2:0] req;
    logic [14:0] pat;
    logic [11:0] duty;
    logic [2:0] gnt;
    logic busy, led1, led2, led3, led4, led5;
    logic [4:0] leds;
    int tests = 0, fails = 0;
    int m_own, m_last, m_ten, m_pc, m_j, m_hit;
    logic [4:0] m_led, m_p;
    logic [3:0] m_d;
    bit m_on = 1'b0;

    led_bank_arbiter #(.NREQ(NREQ), .HOLD_CYCLES(HOLD), .HOLD_W(4), .PWM_W(4)) dut (
        .clk(clk), .resetn(resetn), .req(req), .pat(pat), .duty(duty), .gnt(gnt), .busy(busy),
        .led1(led1), .led2(led2), .led3(led3), .led4(led4), .led5(led5)
    );

    always #5 clk = ~clk;
    assign leds = {led1, led2, led3, led4, led5};

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s at %0t: got %0h expected %0h", nm, $time, act, exp);
        end
    endtask

    // who owns the bank, how long they have held it, and what the pins must show
    always @(posedge clk) begin
        if (!resetn) begin
            m_own = -1; m_last = NREQ - 1; m_ten = 0; m_pc = 0; m_led = '0; m_on = 1'b1;
        end else begin
            m_led = '0;
            if (m_own >= 0) begin
                if (!req[m_own[1:0]] || (m_ten == HOLD && (req & ~(3'd1 << m_own)) != 3'd0)) begin
                    m_own = -1;
                end else begin
                    m_p = 5'(pat >> (5 * m_own));
                    m_d = 4'(duty >> (4 * m_own));
                    if (m_d == 4'hF || m_pc < int'(m_d)) m_led = m_p;
                    if (m_ten < HOLD) m_ten++;
                end
            end else begin
                m_hit = 0;
                for (int k = 1; k <= NREQ; k++) begin
                    m_j = (m_last + k) % NREQ;
                    if (!m_hit && req[m_j[1:0]]) begin
                        m_hit = 1; m_own = m_j; m_last = m_j; m_ten = 0;
                    end
                end
            end
            m_pc = (m_pc + 1) % 16;
        end
    end

    always @(negedge clk) begin
        if (m_on) begin
            check("model_gnt", 32'(gnt), m_own >= 0 ? 32'd1 << m_own : 32'd0);
            check("model_busy", 32'(busy), 32'(m_own >= 0));
            check("model_leds", 32'(leds), 32'(m_led));
        end
    end

    task automatic cyc(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic do_reset;
        resetn = 1'b0;
        cyc(1);
        resetn = 1'b1;
    endtask

    initial begin
        logic [4:0] tbl [4];
        int cnt;
        tbl[0] = 5'b00001; tbl[1] = 5'b10000; tbl[2] = 5'b01110; tbl[3] = 5'b11011;
        resetn = 1'b0; req = 3'b111; pat = '0; duty = '0;
        cyc(3);
        check("rst_gnt", 32'(gnt), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_leds", 32'(leds), 32'd0);
        resetn = 1'b1;
        cyc(1);
        check("first_gnt", 32'(gnt), 32'd1);
        req = 3'b000;
        cyc(1);
        check("drop_gnt", 32'(gnt), 32'd0);
        cyc(2);
        // single owner, solid pattern
        req = 3'b010; pat[9:5] = 5'b10101; duty[7:4] = 4'hF;
        cyc(1);
        check("single_gnt", 32'(gnt), 32'b010);
        for (int k = 0; k < 5; k++) begin
            cyc(1);
            check("single_leds", 32'(leds), 32'b10101);
        end
        req = 3'b000;
        cyc(1);
        check("release_gnt", 32'(gnt), 32'd0);
        check("release_leds", 32'(leds), 32'd0);
        // round robin with 9-cycle tenures and single-cycle gaps
        pat = {3{5'b11111}}; duty = {3{4'hF}};
        resetn = 1'b0;
        cyc(1);
        resetn = 1'b1; req = 3'b111;
        for (int k = 0; k <= 30; k++) begin
            cyc(1);
            check("rr_gnt", 32'(gnt), (k % 10 == 9) ? 32'd0 : 32'd1 << ((k / 10) % 3));
        end
        // lone requester is never preempted
        req = 3'b001;
        do_reset();
        for (int k = 0; k < 100; k++) begin
            cyc(1);
            check("hold_gnt", 32'(gnt), 32'b001);
        end
        // live pattern updates
        for (int k = 0; k < 4; k++) begin
            pat[4:0] = tbl[k];
            cyc(1);
            check("live_leds", 32'(leds), 32'(tbl[k]));
        end
        req = 3'b000;
        cyc(1);
        check("idle_gnt", 32'(gnt), 32'd0);
        cyc(2);
        check("idle_busy", 32'(busy), 32'd0);
        // PWM duty 4 and duty 0
        pat[4:0] = 5'b11111; duty[3:0] = 4'd4; req = 3'b001;
        do_reset();
        cyc(1);
        cnt = 0;
        for (int k = 0; k < 32; k++) begin
            cyc(1);
            if (leds == 5'b11111) cnt++;
        end
        check("pwm4_count", 32'(cnt), 32'd8);
        duty[3:0] = 4'd0;
        cnt = 0;
        for (int k = 0; k < 32; k++) begin
            cyc(1);
            if (leds != 5'b00000) cnt++;
        end
        check("pwm0_count", 32'(cnt), 32'd0);
        duty[3:0] = 4'hF;
        // preemption once tenure has saturated
        cyc(20);
        req = 3'b011;
        cyc(1);
        check("preempt_gap", 32'(gnt), 32'd0);
        cyc(1);
        check("preempt_next", 32'(gnt), 32'b010);
        // owner drops on the same cycle its tenure saturates
        cyc(8);
        req = 3'b001;
        cyc(1);
        check("sat_drop_gap", 32'(gnt), 32'd0);
        cyc(1);
        check("sat_drop_next", 32'(gnt), 32'b001);
        // reset mid-tenure, then requester 0 wins first
        req = 3'b000;
        cyc(3);
        req = 3'b010;
        cyc(6);
        resetn = 1'b0; req = 3'b111;
        cyc(1);
        check("midrst_gnt", 32'(gnt), 32'd0);
        check("midrst_leds", 32'(leds), 32'd0);
        resetn = 1'b1;
        cyc(1);
        check("midrst_first", 32'(gnt), 32'b001);
        cyc(3);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
